// File: rtl/c_hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage core: load-use and branch hazards
// plus a wait-state FSM that freezes the pipe on slow data-memory accesses.
module c_hazard_stall_ctrl #(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              MemAccessM,
    input  logic              mem_ready,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              busy,
    output logic              mem_err
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic lw_stall;
    logic mem_stall;
    logic freeze;

    assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != '0) &&
                       ((Rs1D == RdE) || (Rs2D == RdE));
    assign mem_stall = MemAccessM && !mem_ready;

    // While frozen, E holds its instruction, so hazards are re-evaluated once
    // the memory access completes; they must not act during the freeze.
    always_comb begin
        freeze = 1'b0;
        case (state_q)
            ST_RUN:  freeze = mem_stall;
            ST_WAIT: freeze = !mem_ready;
            default: freeze = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d   = ST_HALT;
                    mem_err_d = 1'b1;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_HALT: begin
                mem_err_d = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Outputs are gated by reset so they drop asynchronously with it.
    assign StallF  = !reset && (freeze || lw_stall);
    assign StallD  = !reset && (freeze || lw_stall);
    assign StallE  = !reset && freeze;
    assign StallM  = !reset && freeze;
    assign FlushD  = !reset && !freeze && PCSrcE;
    assign FlushE  = !reset && !freeze && (lw_stall || PCSrcE);
    assign FlushW  = !reset && freeze;
    assign busy    = !reset && (state_q != ST_RUN);
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_c_hazard_stall_ctrl.sv
// Directed bench for c_hazard_stall_ctrl (TIMEOUT=4); output vector order is
// {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,busy,mem_err}.
module tb_c_hazard_stall_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, RdE;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MemAccessM, mem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, busy, mem_err;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    c_hazard_stall_ctrl #(.REG_AW(5), .TIMEOUT(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .busy(busy), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, busy, mem_err};
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [1:0] rsrc, input logic pcs, input logic macc,
                         input logic rdy);
        Rs1D = rs1; Rs2D = rs2; RdE = rd; ResultSrcE = rsrc;
        PCSrcE = pcs; MemAccessM = macc; mem_ready = rdy;
    endtask

    // Check combinational outputs mid-cycle, then advance past the next edge.
    task automatic step(input string tag, input logic [8:0] exp);
        @(negedge clock);
        check(tag, exp);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd3, 5'd3, 5'd3, 2'b01, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        check("reset_gated", 9'b0000_000_00);
        drive(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        step("idle", 9'b0000_000_00);

        drive(5'd5, 5'd0, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0);
        step("loaduse_rs1", 9'b1100_010_00);
        drive(5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0);
        step("loaduse_rd0", 9'b0000_000_00);
        drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b1, 1'b0, 1'b0);
        step("branch", 9'b0000_110_00);
        drive(5'd1, 5'd7, 5'd7, 2'b01, 1'b1, 1'b0, 1'b0);
        step("branch_loaduse", 9'b1100_110_00);

        drive(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        step("mem_nr1_run", 9'b1111_001_00);
        step("mem_nr2_wait", 9'b1111_001_10);
        step("mem_nr3_wait", 9'b1111_001_10);
        mem_ready = 1'b1;
        step("mem_ready_wait", 9'b0000_000_10);
        step("mem_single_cycle", 9'b0000_000_00);
        MemAccessM = 1'b0;
        step("ready_no_access", 9'b0000_000_00);

        drive(5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0);
        step("prio_frozen_branch", 9'b1111_001_00);
        mem_ready = 1'b1;
        step("prio_release_branch", 9'b0000_110_10);
        drive(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("prio_back_run", 9'b0000_000_00);

        drive(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        step("to_c1", 9'b1111_001_00);
        step("to_c2", 9'b1111_001_10);
        step("to_c3", 9'b1111_001_10);
        step("to_c4", 9'b1111_001_10);
        step("to_c5", 9'b1111_001_10);
        step("halt_entered", 9'b1111_001_11);
        drive(5'd4, 5'd4, 5'd4, 2'b01, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("halt_sticky", 9'b1111_001_11);

        #2 reset = 1'b1;
        #1 check("reset_mid_halt", 9'b0000_000_00);
        drive(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        step("after_halt_reset", 9'b0000_000_00);
        drive(5'd9, 5'd0, 5'd9, 2'b01, 1'b0, 1'b0, 1'b0);
        step("after_halt_loaduse", 9'b1100_010_00);

        drive(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        step("w_c1", 9'b1111_001_00);
        step("w_c2", 9'b1111_001_10);
        #2 reset = 1'b1;
        #1 check("reset_mid_wait", 9'b0000_000_00);
        drive(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        step("after_wait_reset", 9'b0000_000_00);
        PCSrcE = 1'b1;
        step("after_wait_branch", 9'b0000_110_00);
        PCSrcE = 1'b0;
        MemAccessM = 1'b1;
        mem_ready  = 1'b1;
        step("after_wait_mem_ok", 9'b0000_000_00);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
